// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart Avalon arbiter: mode names, FSM encoding, helpers.
package uart_arb_pkg;

   localparam string ARB_ROUND = "ROUND";
   localparam string ARB_FIXED = "FIXED";

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_e;

   // Width of a pointer able to index n masters (at least one bit).
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner picker: round-robin from ptr, or lowest index when mode_fixed.
module uart_arb_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic            mode_fixed,
   output logic [NREQ-1:0] win
);

   logic [PW-1:0] idx;
   logic          found;

   // Walk NREQ candidates starting at the base index, wrapping at NREQ-1.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = mode_fixed ? '0 : ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!found && req[idx]) begin
            win[idx] = 1'b1;
            found    = 1'b1;
         end
         idx = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/uart_arb.sv
// Avalon MM arbiter sharing the uart slave port between NREQ masters, with per-master lock.
module uart_arb
   import uart_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AAW  = 1,
   parameter int unsigned ADW  = 32,
   parameter int unsigned ABW  = ADW / 8,
   parameter string       ARB  = "ROUND"
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     m_read,
   input  logic [NREQ-1:0]     m_write,
   input  logic [NREQ-1:0]     m_lock,
   input  logic [NREQ*AAW-1:0] m_address,
   input  logic [NREQ*ABW-1:0] m_byteenable,
   input  logic [NREQ*ADW-1:0] m_writedata,
   output logic [ADW-1:0]      m_readdata,
   output logic [NREQ-1:0]     m_waitrequest,
   output logic                s_read,
   output logic                s_write,
   output logic [AAW-1:0]      s_address,
   output logic [ABW-1:0]      s_byteenable,
   output logic [ADW-1:0]      s_writedata,
   input  logic [ADW-1:0]      s_readdata,
   input  logic                s_waitrequest
);

   localparam int unsigned PW       = ptr_width(NREQ);
   localparam bit          IS_FIXED = (ARB == ARB_FIXED);

   arb_state_e      state;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   ptr;
   logic            locked;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] pick;
   logic [PW-1:0]   g_idx;
   logic [PW-1:0]   ptr_next;
   logic            busy;
   logic            req_g;
   logic            rd_g;
   logic            wr_g;
   logic            lock_g;
   logic            done;
   logic [AAW-1:0]  addr_g;
   logic [ABW-1:0]  be_g;
   logic [ADW-1:0]  wd_g;

   assign req    = m_read | m_write;
   assign busy   = (state == ST_BUSY);
   assign req_g  = |(req & gnt);
   assign rd_g   = |(m_read & gnt);
   assign wr_g   = |(m_write & gnt);
   assign lock_g = |(m_lock & gnt);
   assign done   = busy & req_g & ~s_waitrequest;

   uart_arb_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req        (req),
      .ptr        (ptr),
      .mode_fixed (IS_FIXED),
      .win        (pick)
   );

   // Select the granted master's payload and index; gnt is zero outside BUSY, giving zeros.
   always_comb begin
      g_idx  = '0;
      addr_g = '0;
      be_g   = '0;
      wd_g   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            g_idx  = PW'(i);
            addr_g = addr_g | m_address[i*AAW +: AAW];
            be_g   = be_g | m_byteenable[i*ABW +: ABW];
            wd_g   = wd_g | m_writedata[i*ADW +: ADW];
         end
      end
   end

   assign ptr_next = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + 1'b1;

   // Slave command follows the granted master; write wins over a simultaneous read.
   assign s_read        = busy & rd_g & ~wr_g;
   assign s_write       = busy & wr_g;
   assign s_address     = addr_g;
   assign s_byteenable  = be_g;
   assign s_writedata   = wd_g;
   assign m_readdata    = busy ? s_readdata : '0;
   assign m_waitrequest = busy ? (~gnt | {NREQ{s_waitrequest}}) : '1;

   // Grant FSM: arbitrate in IDLE, hold through the transfer, keep the grant while locked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         gnt    <= '0;
         ptr    <= '0;
         locked <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  gnt   <= pick;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (done && lock_g) begin
                  locked <= 1'b1;
               end else if (done || (!req_g && !(locked && lock_g))) begin
                  state  <= ST_IDLE;
                  gnt    <= '0;
                  locked <= 1'b0;
                  if (!IS_FIXED) ptr <= ptr_next;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_arb.sv
// Self-checking bench for uart_arb: a 2-master round-robin instance and a 3-master fixed instance.
module tb_uart_arb;

   typedef struct {
      logic [31:0] wd;
      logic        addr;
      logic [3:0]  be;
      bit          lock;
      int          cyc;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   tgt = 1'b0;
   int   ws_prob = 0;

   logic [2:0]       drv_read  = '0;
   logic [2:0]       drv_write = '0;
   logic [2:0]       drv_lock  = '0;
   logic [2:0]       drv_addr  = '0;
   logic [2:0][3:0]  drv_be    = '0;
   logic [2:0][31:0] drv_wd    = '0;
   logic             slv_wait  = 1'b0;
   logic [31:0]      slv_rdata = '0;

   item_t mq[3][$];
   item_t slog[$];

   always #5 clk = ~clk;

   // Round-robin instance, NREQ=2
   wire [1:0]  r_m_read  = tgt ? 2'b00 : drv_read[1:0];
   wire [1:0]  r_m_write = tgt ? 2'b00 : drv_write[1:0];
   wire [1:0]  r_m_lock  = tgt ? 2'b00 : drv_lock[1:0];
   wire [1:0]  r_m_addr  = drv_addr[1:0];
   wire [7:0]  r_m_be    = drv_be[1:0];
   wire [63:0] r_m_wd    = drv_wd[1:0];
   logic [31:0] r_rdata;
   logic [1:0]  r_wait;
   logic        r_s_read, r_s_write;
   logic [0:0]  r_s_addr;
   logic [3:0]  r_s_be;
   logic [31:0] r_s_wd;

   uart_arb #(.NREQ(2), .AAW(1), .ADW(32), .ABW(4), .ARB("ROUND")) dut_r (
      .clk(clk), .rst(rst),
      .m_read(r_m_read), .m_write(r_m_write), .m_lock(r_m_lock),
      .m_address(r_m_addr), .m_byteenable(r_m_be), .m_writedata(r_m_wd),
      .m_readdata(r_rdata), .m_waitrequest(r_wait),
      .s_read(r_s_read), .s_write(r_s_write), .s_address(r_s_addr),
      .s_byteenable(r_s_be), .s_writedata(r_s_wd),
      .s_readdata(slv_rdata), .s_waitrequest(slv_wait)
   );

   // Fixed-priority instance, NREQ=3
   wire [2:0]  f_m_read  = tgt ? drv_read  : 3'b000;
   wire [2:0]  f_m_write = tgt ? drv_write : 3'b000;
   wire [2:0]  f_m_lock  = tgt ? drv_lock  : 3'b000;
   wire [2:0]  f_m_addr  = drv_addr;
   wire [11:0] f_m_be    = drv_be;
   wire [95:0] f_m_wd    = drv_wd;
   logic [31:0] f_rdata;
   logic [2:0]  f_wait;
   logic        f_s_read, f_s_write;
   logic [0:0]  f_s_addr;
   logic [3:0]  f_s_be;
   logic [31:0] f_s_wd;

   uart_arb #(.NREQ(3), .AAW(1), .ADW(32), .ABW(4), .ARB("FIXED")) dut_f (
      .clk(clk), .rst(rst),
      .m_read(f_m_read), .m_write(f_m_write), .m_lock(f_m_lock),
      .m_address(f_m_addr), .m_byteenable(f_m_be), .m_writedata(f_m_wd),
      .m_readdata(f_rdata), .m_waitrequest(f_wait),
      .s_read(f_s_read), .s_write(f_s_write), .s_address(f_s_addr),
      .s_byteenable(f_s_be), .s_writedata(f_s_wd),
      .s_readdata(slv_rdata), .s_waitrequest(slv_wait)
   );

   wire [2:0]  obs_wait    = tgt ? f_wait : {1'b1, r_wait};
   wire        obs_s_read  = tgt ? f_s_read : r_s_read;
   wire        obs_s_write = tgt ? f_s_write : r_s_write;
   wire [31:0] obs_s_wd    = tgt ? f_s_wd : r_s_wd;
   wire        obs_s_addr  = tgt ? f_s_addr[0] : r_s_addr[0];
   wire [3:0]  obs_s_be    = tgt ? f_s_be : r_s_be;
   wire [31:0] obs_rdata   = tgt ? f_rdata : r_rdata;

   task automatic clear_drive();
      drv_read  = '0;
      drv_write = '0;
      drv_lock  = '0;
      slv_wait  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_drive();
      for (int i = 0; i < 3; i++) mq[i].delete();
      slog.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic item_t make_item(input int id, input logic [7:0] ch, input bit lk);
      item_t it;
      it.wd   = {8'(id), 16'($urandom), ch};
      it.addr = 1'($urandom);
      it.be   = 4'($urandom_range(15, 1));
      it.lock = lk;
      it.cyc  = 0;
      return it;
   endfunction

   // One clock of the master/slave models: drive queue heads, then observe the cycle.
   task automatic cycle();
      item_t e;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (mq[i].size() > 0) begin
            drv_write[i] = 1'b1;
            drv_wd[i]    = mq[i][0].wd;
            drv_addr[i]  = mq[i][0].addr;
            drv_be[i]    = mq[i][0].be;
            drv_lock[i]  = mq[i][0].lock;
         end else begin
            drv_write[i] = 1'b0;
            drv_lock[i]  = 1'b0;
         end
      end
      drv_read = '0;
      slv_wait = (ws_prob > 0) && (int'($urandom_range(99, 0)) < ws_prob);
      #1;
      for (int i = 0; i < 3; i++)
         if (drv_write[i] && !obs_wait[i]) void'(mq[i].pop_front());
      if (obs_s_write && !slv_wait) begin
         e.wd = obs_s_wd; e.addr = obs_s_addr; e.be = obs_s_be; e.lock = 1'b0; e.cyc = cyc;
         slog.push_back(e);
      end
      cyc++;
   endtask

   task automatic run_queues(input int budget, output bit timeout);
      int n = 0;
      while ((mq[0].size() + mq[1].size() + mq[2].size()) > 0 && n < budget) begin
         cycle();
         n++;
      end
      repeat (3) cycle();
      timeout = (mq[0].size() + mq[1].size() + mq[2].size()) > 0;
   endtask

   // Reference: expected slave order from the arbitration rules, assuming continuous requests.
   task automatic model(input bit fixed, input int n, output item_t expq[$]);
      item_t q[3][$];
      item_t it;
      int ptr = 0;
      int g = -1;
      for (int i = 0; i < 3; i++) q[i] = mq[i];
      expq = {};
      while ((q[0].size() + q[1].size() + q[2].size()) > 0) begin
         if (g < 0) begin
            for (int k = 0; k < n; k++) begin
               int c = fixed ? k : (ptr + k) % n;
               if (g < 0 && q[c].size() > 0) g = c;
            end
         end
         it = q[g].pop_front();
         expq.push_back(it);
         if (!(it.lock && q[g].size() > 0)) begin
            ptr = (g + 1) % n;
            g = -1;
         end
      end
   endtask

   task automatic test_reset();
      tgt = 1'b0;
      drv_write = 3'b111; drv_read = 3'b111;
      drv_wd = {32'h33333333, 32'h22222222, 32'h11111111};
      drv_be = 12'hfff; drv_addr = 3'b111;
      slv_rdata = 32'hdeadbeef;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({r_wait, f_wait} !== 5'b11111) begin
         failures++; $display("FAIL reset_waitreq got=%b exp=11111", {r_wait, f_wait});
      end
      checks++;
      if ({r_s_read, r_s_write, f_s_read, f_s_write} !== 4'b0000) begin
         failures++; $display("FAIL reset_cmd got=%b exp=0000", {r_s_read, r_s_write, f_s_read, f_s_write});
      end
      checks++;
      if ({r_s_wd, r_s_addr, r_s_be, f_s_wd, f_s_addr, f_s_be} !== 74'h0) begin
         failures++; $display("FAIL reset_payload got=%h exp=0", {r_s_wd, r_s_addr, r_s_be, f_s_wd, f_s_addr, f_s_be});
      end
      checks++;
      if ({r_rdata, f_rdata} !== 64'h0) begin
         failures++; $display("FAIL reset_rdata got=%h exp=0", {r_rdata, f_rdata});
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      tgt = 1'b0;
      @(negedge clk);
      drv_write[0] = 1'b1; drv_wd[0] = 32'h48; drv_addr[0] = 1'b1; drv_be[0] = 4'hf; slv_wait = 1'b1;
      #1;
      checks++;
      if (obs_s_write !== 1'b0) begin
         failures++; $display("FAIL single_arb_gap got=%b exp=0", obs_s_write);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         slv_wait = 1'b1;
         #1;
         checks++;
         if ({obs_s_write, obs_s_wd, obs_s_addr, obs_s_be} !== {1'b1, 32'h48, 1'b1, 4'hf}) begin
            failures++; $display("FAIL single_cmd got=%b/%h exp=1/48", obs_s_write, obs_s_wd);
         end
         checks++;
         if (obs_wait[1:0] !== 2'b11) begin
            failures++; $display("FAIL single_wait_held got=%b exp=11", obs_wait[1:0]);
         end
      end
      @(negedge clk);
      slv_wait = 1'b0;
      #1;
      checks++;
      if ({obs_s_write, obs_wait[1:0]} !== 3'b110) begin
         failures++; $display("FAIL single_wait_release got=%b exp=110", {obs_s_write, obs_wait[1:0]});
      end
      @(negedge clk);
      drv_write[0] = 1'b0;
      #1;
      checks++;
      if ({obs_s_write, obs_wait[1:0]} !== 3'b011) begin
         failures++; $display("FAIL single_idle_after got=%b exp=011", {obs_s_write, obs_wait[1:0]});
      end
   endtask

   task automatic test_read();
      logic [31:0] rd;
      tgt = 1'b0;
      @(negedge clk);
      drv_read[1] = 1'b1; drv_addr[1] = 1'b0; slv_wait = 1'b0; slv_rdata = $urandom;
      #1;
      checks++;
      if (obs_s_read !== 1'b0) begin
         failures++; $display("FAIL read_arb_gap got=%b exp=0", obs_s_read);
      end
      @(negedge clk);
      rd = $urandom; slv_rdata = rd;
      #1;
      checks++;
      if ({obs_s_read, obs_s_write, obs_rdata, obs_wait[1:0]} !== {1'b1, 1'b0, rd, 2'b01}) begin
         failures++; $display("FAIL read_data got=%b%b/%h/%b exp=10/%h/01", obs_s_read, obs_s_write, obs_rdata, obs_wait[1:0], rd);
      end
      @(negedge clk);
      drv_read = 3'b001; drv_write = 3'b001; drv_wd[0] = 32'h55;
      #1;
      checks++;
      if (obs_rdata !== 32'h0) begin
         failures++; $display("FAIL read_idle_zero got=%h exp=0", obs_rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({obs_s_read, obs_s_write} !== 2'b01) begin
         failures++; $display("FAIL read_write_wins got=%b exp=01", {obs_s_read, obs_s_write});
      end
      @(negedge clk);
      clear_drive();
   endtask

   task automatic test_round_robin();
      item_t expq[$];
      bit to;
      tgt = 1'b0;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         ws_prob = 30;
         for (int m = 0; m < 2; m++)
            for (int c = 0; c < 3; c++) mq[m].push_back(make_item(m, 8'($urandom_range(126, 32)), 1'b0));
         model(1'b0, 2, expq);
         run_queues(200, to);
         checks++;
         if (to) begin failures++; $display("FAIL rr_timeout iter=%0d", it); end
         checks++;
         if (slog.size() !== expq.size()) begin
            failures++; $display("FAIL rr_count got=%0d exp=%0d", slog.size(), expq.size());
         end
         for (int k = 0; k < slog.size() && k < expq.size(); k++) begin
            checks++;
            if ({slog[k].wd, slog[k].addr, slog[k].be} !== {expq[k].wd, expq[k].addr, expq[k].be}) begin
               failures++; $display("FAIL rr_order k=%0d got=%h exp=%h", k, slog[k].wd, expq[k].wd);
            end
         end
      end
   endtask

   task automatic test_lock();
      item_t expq[$];
      logic [7:0] msg [6];
      int prev;
      bit to;
      msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c};
      do_reset();
      tgt = 1'b0;
      ws_prob = 0;
      mq[0].push_back(make_item(0, 8'h30, 1'b0));
      mq[0].push_back(make_item(0, 8'h31, 1'b0));
      mq[0].push_back(make_item(0, 8'h32, 1'b0));
      for (int c = 0; c < 6; c++) mq[1].push_back(make_item(1, msg[c], 1'b1));
      model(1'b0, 2, expq);
      run_queues(200, to);
      checks++;
      if (to) begin failures++; $display("FAIL lock_timeout"); end
      checks++;
      if (slog.size() !== expq.size()) begin
         failures++; $display("FAIL lock_count got=%0d exp=%0d", slog.size(), expq.size());
      end
      for (int k = 0; k < slog.size() && k < expq.size(); k++) begin
         checks++;
         if ({slog[k].wd, slog[k].addr, slog[k].be} !== {expq[k].wd, expq[k].addr, expq[k].be}) begin
            failures++; $display("FAIL lock_order k=%0d got=%h exp=%h", k, slog[k].wd, expq[k].wd);
         end
      end
      prev = -1;
      foreach (slog[k]) begin
         if (slog[k].wd[31:24] == 8'd1) begin
            if (prev >= 0) begin
               checks++;
               if (slog[k].cyc - prev !== 1) begin
                  failures++; $display("FAIL lock_gap got=%0d exp=1", slog[k].cyc - prev);
               end
            end
            prev = slog[k].cyc;
         end
      end
   endtask

   task automatic test_fixed();
      item_t expq[$];
      int last_m0;
      int m2_early;
      bit to;
      do_reset();
      tgt = 1'b1;
      ws_prob = 25;
      for (int c = 0; c < 4; c++) mq[0].push_back(make_item(0, 8'($urandom), 1'b0));
      for (int m = 1; m < 3; m++)
         for (int c = 0; c < 3; c++) mq[m].push_back(make_item(m, 8'($urandom), 1'b0));
      model(1'b1, 3, expq);
      run_queues(300, to);
      checks++;
      if (to) begin failures++; $display("FAIL fixed_timeout"); end
      checks++;
      if (slog.size() !== expq.size()) begin
         failures++; $display("FAIL fixed_count got=%0d exp=%0d", slog.size(), expq.size());
      end
      for (int k = 0; k < slog.size() && k < expq.size(); k++) begin
         checks++;
         if ({slog[k].wd, slog[k].addr, slog[k].be} !== {expq[k].wd, expq[k].addr, expq[k].be}) begin
            failures++; $display("FAIL fixed_order k=%0d got=%h exp=%h", k, slog[k].wd, expq[k].wd);
         end
      end
      last_m0 = -1;
      foreach (slog[k]) if (slog[k].wd[31:24] == 8'd0) last_m0 = k;
      m2_early = 0;
      for (int k = 0; k < last_m0; k++) if (slog[k].wd[31:24] == 8'd2) m2_early++;
      checks++;
      if (m2_early !== 0) begin
         failures++; $display("FAIL fixed_m2_starved got=%0d exp=0", m2_early);
      end
      tgt = 1'b0;
   endtask

   task automatic test_random();
      item_t expq[$];
      bit to;
      for (int it = 0; it < 6; it++) begin
         int n;
         do_reset();
         tgt = 1'($urandom);
         n = tgt ? 3 : 2;
         ws_prob = int'($urandom_range(50, 0));
         for (int m = 0; m < n; m++) begin
            int len = int'($urandom_range(5, 1));
            for (int c = 0; c < len; c++)
               mq[m].push_back(make_item(m, 8'($urandom), $urandom_range(99, 0) < 30));
         end
         model(tgt, n, expq);
         run_queues(400, to);
         checks++;
         if (to) begin failures++; $display("FAIL rand_timeout iter=%0d", it); end
         checks++;
         if (slog.size() !== expq.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", slog.size(), expq.size());
         end
         for (int k = 0; k < slog.size() && k < expq.size(); k++) begin
            checks++;
            if ({slog[k].wd, slog[k].addr, slog[k].be} !== {expq[k].wd, expq[k].addr, expq[k].be}) begin
               failures++; $display("FAIL rand_order it=%0d k=%0d got=%h exp=%h", it, k, slog[k].wd, expq[k].wd);
            end
         end
      end
      tgt = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] a, b, a2;
      do_reset();
      tgt = 1'b0;
      a = 32'h0000_4100; b = 32'h0100_4200; a2 = 32'h0000_4300;
      @(negedge clk);
      drv_write = 3'b011; drv_wd[0] = a; drv_wd[1] = b; slv_wait = 1'b0;
      #1;
      @(negedge clk);
      #1;
      checks++;
      if ({obs_s_write, obs_s_wd} !== {1'b1, a}) begin
         failures++; $display("FAIL rstmid_m0_first got=%b/%h exp=1/%h", obs_s_write, obs_s_wd, a);
      end
      @(negedge clk);
      drv_write[0] = 1'b0; slv_wait = 1'b1;
      #1;
      @(negedge clk);
      slv_rdata = 32'h1234_5678;
      #1;
      checks++;
      if ({obs_s_write, obs_s_wd} !== {1'b1, b}) begin
         failures++; $display("FAIL rstmid_m1_busy got=%b/%h exp=1/%h", obs_s_write, obs_s_wd, b);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({obs_s_write, obs_wait, obs_rdata} !== {1'b0, 3'b111, 32'h0}) begin
         failures++; $display("FAIL rstmid_async got=%b/%b/%h exp=0/111/0", obs_s_write, obs_wait, obs_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      drv_write = 3'b011; drv_wd[0] = a2; slv_wait = 1'b0;
      #1;
      @(negedge clk);
      #1;
      checks++;
      if ({obs_s_write, obs_s_wd} !== {1'b1, a2}) begin
         failures++; $display("FAIL rstmid_ptr0 got=%b/%h exp=1/%h", obs_s_write, obs_s_wd, a2);
      end
      @(negedge clk);
      clear_drive();
   endtask

   task automatic test_withdraw();
      logic [31:0] a, b;
      do_reset();
      tgt = 1'b0;
      a = 32'h0000_0061; b = 32'h0100_0062;
      @(negedge clk);
      drv_write = 3'b011; drv_wd[0] = a; drv_wd[1] = b; slv_wait = 1'b1;
      #1;
      @(negedge clk);
      #1;
      checks++;
      if ({obs_s_write, obs_s_wd} !== {1'b1, a}) begin
         failures++; $display("FAIL wd_m0_busy got=%b/%h exp=1/%h", obs_s_write, obs_s_wd, a);
      end
      @(negedge clk);
      drv_write[0] = 1'b0;
      #1;
      checks++;
      if (obs_s_write !== 1'b0) begin
         failures++; $display("FAIL wd_comb_drop got=%b exp=0", obs_s_write);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({obs_s_write, obs_wait} !== {1'b0, 3'b111}) begin
         failures++; $display("FAIL wd_idle got=%b/%b exp=0/111", obs_s_write, obs_wait);
      end
      @(negedge clk);
      slv_wait = 1'b0;
      #1;
      checks++;
      if ({obs_s_write, obs_s_wd} !== {1'b1, b}) begin
         failures++; $display("FAIL wd_m1_next got=%b/%h exp=1/%h", obs_s_write, obs_s_wd, b);
      end
      @(negedge clk);
      clear_drive();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_read();
      test_round_robin();
      test_lock();
      test_fixed();
      test_random();
      test_reset_mid();
      test_withdraw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
